deserializer_rx: RTL and testbench

Receive-side counterpart of the team's MSB-first serial link. Samples a serial bit stream qualified by a data-valid flag and assembles MSG_SIZE-bit words, first bit received landing in the MSB. Delivers each word through a one-entry valid/ready output register. Reports framing errors (flag dropped mid-word) and overrun errors (output register still occupied). Sits between the serial pad logic and the parallel message consumer. It exposes the same bit-count convention the transmitter uses, where count == MSG_SIZE means a complete word.

---
 rtl/deserializer_rx_pkg.sv | 15 +
 rtl/deserializer_rx_hold_reg.sv | 49 ++++
 rtl/deserializer_rx.sv | 105 ++++++++++
 tb/tb_deserializer_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/deserializer_rx_pkg.sv
// Shared definitions for the serial link blocks: receive FSM encoding and the
// bit-counter width rule (wide enough to hold MSG_SIZE itself).
package deserializer_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_e;

  function automatic int cnt_width(input int msg_size);
    return $clog2(msg_size) + 1;
  endfunction

endpackage

// File: rtl/deserializer_rx_hold_reg.sv
// Single-entry valid/ready output register. A new word arriving while the
// entry is full and not being drained is dropped and flagged via overrun.
module rx_hold_reg #(
  parameter int MSG_SIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [MSG_SIZE-1:0] load_data,
  input  logic                ready,
  output logic [MSG_SIZE-1:0] data_out,
  output logic                valid,
  output logic                overrun
);

  logic [MSG_SIZE-1:0] data_q, data_d;
  logic                valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    overrun = 1'b0;
    if (load) begin
      // Same-edge drain frees the slot, so the new word may replace the old one.
      if (!valid_q || ready) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        overrun = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;

endmodule

// File: rtl/deserializer_rx.sv
// MSB-first serial receiver: assembles MSG_SIZE-bit words from a flagged bit
// stream and hands them to a one-entry output register with sticky error flags.
module deserializer_rx
  import deserializer_rx_pkg::*;
#(
  parameter  int MSG_SIZE = 64,
  localparam int CW       = cnt_width(MSG_SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                iData_in,
  input  logic                iData_flag,
  input  logic                iReady,
  input  logic                iErr_clr,
  output logic [MSG_SIZE-1:0] oData_out,
  output logic                oValid,
  output logic [CW-1:0]       oCounter,
  output logic                oFrame_err,
  output logic                oOverrun_err
);

  rx_state_e           state_q, state_d;
  logic [MSG_SIZE-1:0] sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_err_q, overrun_err_d;
  logic                word_load;
  logic                frame_set;
  logic                overrun_set;
  logic [MSG_SIZE-1:0] word_data;

  assign word_data = {sr_q[MSG_SIZE-2:0], iData_in};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_load = 1'b0;
    frame_set = 1'b0;
    if (ena) begin
      if (iData_flag) begin
        sr_d = word_data;
        if (state_q == SHIFT) begin
          if (cnt_q == CW'(MSG_SIZE - 1)) begin
            word_load = 1'b1;
            cnt_d     = CW'(MSG_SIZE);
            state_d   = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          // A new word may start straight out of DONE with no idle gap.
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end else if (state_q == SHIFT) begin
        frame_set = 1'b1;
        sr_d      = '0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
    end
  end

  // Set beats clear when both land on the same edge.
  always_comb begin
    frame_err_d   = frame_set   ? 1'b1 : (iErr_clr ? 1'b0 : frame_err_q);
    overrun_err_d = overrun_set ? 1'b1 : (iErr_clr ? 1'b0 : overrun_err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      cnt_q         <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  rx_hold_reg #(
    .MSG_SIZE(MSG_SIZE)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (word_load),
    .load_data(word_data),
    .ready    (iReady),
    .data_out (oData_out),
    .valid    (oValid),
    .overrun  (overrun_set)
  );

  assign oCounter     = cnt_q;
  assign oFrame_err   = frame_err_q;
  assign oOverrun_err = overrun_err_q;

endmodule

// File: tb/tb_deserializer_rx.sv
// Bench for deserializer_rx (MSG_SIZE=8): directed vectors, an integer-level
// reference model checked every negedge, and literal spot checks.
module tb_deserializer_rx;

  localparam int MS = 8;
  localparam int CW = $clog2(MS) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ena = 1'b0;
  logic          iData_in = 1'b0;
  logic          iData_flag = 1'b0;
  logic          iReady = 1'b0;
  logic          iErr_clr = 1'b0;
  logic [MS-1:0] oData_out;
  logic          oValid;
  logic [CW-1:0] oCounter;
  logic          oFrame_err;
  logic          oOverrun_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bits received so far (0 = idle, MS = word just done).
  int       m_cnt = 0;
  int       m_acc = 0;
  int       m_data = 0;
  bit       m_valid = 0;
  bit       m_fe = 0;
  bit       m_ov = 0;

  deserializer_rx #(.MSG_SIZE(MS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .iData_in    (iData_in),
    .iData_flag  (iData_flag),
    .iReady      (iReady),
    .iErr_clr    (iErr_clr),
    .oData_out   (oData_out),
    .oValid      (oValid),
    .oCounter    (oCounter),
    .oFrame_err  (oFrame_err),
    .oOverrun_err(oOverrun_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_acc = 0; m_data = 0; m_valid = 0; m_fe = 0; m_ov = 0;
  endtask

  task automatic model_edge(input bit en, input bit flag, input bit b, input bit rdy, input bit clr);
    bit in_word, fr, ov, nw;
    in_word = (m_cnt > 0) && (m_cnt < MS);
    fr = 0; ov = 0; nw = 0;
    if (en) begin
      if (flag) begin
        m_acc = ((m_acc * 2) + int'(b)) % (1 << MS);
        m_cnt = in_word ? m_cnt + 1 : 1;
        nw = (m_cnt == MS);
      end else if (in_word) begin
        fr = 1;
        m_cnt = 0;
      end
    end
    if (nw) begin
      if (!m_valid || rdy) begin
        m_data = m_acc;
        m_valid = 1;
      end else begin
        ov = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    m_fe = fr ? 1'b1 : (clr ? 1'b0 : m_fe);
    m_ov = ov ? 1'b1 : (clr ? 1'b0 : m_ov);
  endtask

  always @(negedge clk) begin
    check("data", 64'(oData_out), 64'(m_data));
    check("valid", 64'(oValid), 64'(m_valid));
    check("counter", 64'(oCounter), 64'(m_cnt));
    check("frame_err", 64'(oFrame_err), 64'(m_fe));
    check("overrun_err", 64'(oOverrun_err), 64'(m_ov));
  end

  task automatic step(input bit en, input bit flag, input bit b, input bit rdy, input bit clr);
    ena = en; iData_flag = flag; iData_in = b; iReady = rdy; iErr_clr = clr;
    @(posedge clk);
    model_edge(en, flag, b, rdy, clr);
    #1;
  endtask

  // Sends a full word MSB first; ready is asserted only on the last bit when rdy_last.
  task automatic send_word(input logic [MS-1:0] w, input bit rdy, input bit rdy_last);
    for (int i = MS - 1; i >= 0; i--)
      step(1, 1, w[i], (i == 0) ? rdy_last : rdy, 0);
  endtask

  initial begin
    logic [MS-1:0] w;
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("reset_data", 64'(oData_out), 64'h0);
    check("reset_valid", 64'(oValid), 64'h0);
    check("reset_counter", 64'(oCounter), 64'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Basic word
    send_word(8'hA5, 1, 1);
    check("basic_data", 64'(oData_out), 64'hA5);
    check("basic_valid", 64'(oValid), 64'h1);
    check("basic_counter", 64'(oCounter), 64'd8);
    check("basic_no_ferr", 64'(oFrame_err), 64'h0);
    step(1, 0, 0, 1, 0);
    check("basic_valid_drop", 64'(oValid), 64'h0);
    $display("txn basic: data=%h", oData_out);

    // Back-to-back with backpressure: second word lost
    send_word(8'h3C, 0, 0);
    send_word(8'hC3, 0, 0);
    check("bp_data_kept", 64'(oData_out), 64'h3C);
    check("bp_overrun", 64'(oOverrun_err), 64'h1);
    step(1, 0, 0, 1, 1);
    check("bp_overrun_clr", 64'(oOverrun_err), 64'h0);
    $display("txn backpressure: data=3C overrun seen");

    // Same again but drained on the completion edge
    send_word(8'h3C, 0, 0);
    send_word(8'hC3, 0, 1);
    check("drain_data", 64'(oData_out), 64'hC3);
    check("drain_valid", 64'(oValid), 64'h1);
    check("drain_no_overrun", 64'(oOverrun_err), 64'h0);
    step(1, 0, 0, 1, 0);
    $display("txn drain-on-edge: data=C3");

    // Framing error after 4 bits
    step(1, 1, 1, 1, 0); step(1, 1, 0, 1, 0); step(1, 1, 1, 1, 0); step(1, 1, 1, 1, 0);
    step(1, 0, 0, 1, 0);
    check("frame_err_set", 64'(oFrame_err), 64'h1);
    check("frame_counter", 64'(oCounter), 64'h0);
    check("frame_valid", 64'(oValid), 64'h0);
    send_word(8'hFF, 1, 1);
    check("frame_then_ff", 64'(oData_out), 64'hFF);
    step(1, 0, 0, 1, 1);
    check("frame_err_clr", 64'(oFrame_err), 64'h0);
    $display("txn framing: err then FF received");

    // ena gap after bit 5 of 8'h81
    w = 8'h81;
    for (int i = MS - 1; i >= 3; i--) step(1, 1, w[i], 1, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 1'(k), 1, 0);
    check("ena_counter_hold", 64'(oCounter), 64'd5);
    for (int i = 2; i >= 0; i--) step(1, 1, w[i], 1, 0);
    check("ena_data", 64'(oData_out), 64'h81);
    step(1, 0, 0, 1, 0);
    $display("txn ena-gap: data=81");

    // Async reset after bit 6 of a word, with a word already held
    send_word(8'h77, 0, 0);
    w = 8'hE7;
    for (int i = MS - 1; i >= 2; i--) step(1, 1, w[i], 0, 0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_data", 64'(oData_out), 64'h0);
    check("rst_async_valid", 64'(oValid), 64'h0);
    check("rst_async_counter", 64'(oCounter), 64'h0);
    ena = 1'b0; iData_flag = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    send_word(8'h5A, 1, 1);
    check("rst_then_5a", 64'(oData_out), 64'h5A);
    step(1, 0, 0, 1, 0);
    $display("txn reset-mid-word: then data=5A");

    // Clear and frame error on the same edge: set wins
    step(1, 1, 1, 1, 0); step(1, 1, 0, 1, 0); step(1, 1, 1, 1, 0);
    step(1, 0, 0, 1, 1);
    check("set_beats_clr", 64'(oFrame_err), 64'h1);
    step(1, 0, 0, 1, 1);
    check("clr_after", 64'(oFrame_err), 64'h0);
    $display("txn set-vs-clear: frame_err kept");

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
